// File: rtl/cheri_pkg.sv
// Shared CHERI capability types and helpers for the temporal-revocation check path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: reg_cap_t, get_bound33(), trvk_req_t, cap_is_sealed().
package cheri_pkg;

  localparam int unsigned TOP_W   = 9;
  localparam int unsigned EXP_W   = 5;
  localparam int unsigned PERMS_W = 5;
  // Widest request tag / channel index any instance may carry through the pipe.
  localparam int unsigned MaxIdW  = 8;
  localparam int unsigned MaxChW  = 3;

  typedef struct packed {
    logic               valid;
    logic [TOP_W-1:0]   top;
    logic [TOP_W-1:0]   base;
    logic [EXP_W-1:0]   exp;
    logic [PERMS_W-1:0] cperms;
    logic               top_cor;
    logic               base_cor;
  } reg_cap_t;

  typedef struct packed {
    reg_cap_t          cap;
    logic [31:0]       data;
    logic [MaxIdW-1:0] id;
    logic [MaxChW-1:0] ch;
  } trvk_req_t;

  // Rebuild a 33-bit bound from its compressed field, the address and the
  // region correction (cor = 2'b11 means the bound lies one block below addr).
  function automatic logic [32:0] get_bound33(logic [TOP_W-1:0] top_or_base,
                                              logic [1:0]       cor,
                                              logic [EXP_W-1:0] exp_val,
                                              logic [31:0]      addr);
    logic [32:0] cor_val;
    logic [32:0] mask;
    logic [32:0] result;
    cor_val = cor[1] ? {33{1'b1}} : {32'h0, cor[0]};
    cor_val = (cor_val << exp_val) << TOP_W;
    mask    = ({33{1'b1}} << exp_val) << TOP_W;
    result  = (({1'b0, addr} & mask) + cor_val) | ({24'h0, top_or_base} << exp_val);
    return result;
  endfunction

  // Sealed: no global/execute-class bits but a non-zero otype-style field.
  function automatic logic cap_is_sealed(logic [PERMS_W-1:0] cperms);
    return (cperms[4:3] == 2'b00) && (|cperms[2:0]);
  endfunction

endpackage

// File: rtl/cheri_rr_arb.sv
// Round-robin arbiter, one-hot grant; pointer moves to granted+1 after every grant.
// Latency: combinational grant, pointer updates on the clock edge.
// Backpressure: none internally; grant is forced to zero while rst_i is high.
// Ports: clk_i, rst_i, req_i[NumReq] requests, gnt_o[NumReq] one-hot grant.
module cheri_rr_arb #(
  parameter int unsigned NumReq = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o
);

  localparam int unsigned ChW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned IdxW = ChW + 1;

  logic [ChW-1:0] rr_q;
  logic [ChW-1:0] rr_d;

  always_comb begin
    logic [IdxW-1:0] idx;
    logic [IdxW-1:0] nxt;
    logic            found;
    gnt_o = '0;
    rr_d  = rr_q;
    found = 1'b0;
    idx   = '0;
    nxt   = '0;
    // Scan from the pointer upwards, wrapping; first requester wins.
    for (int i = 0; i < NumReq; i++) begin
      idx = IdxW'(rr_q) + IdxW'(i);
      if (idx >= IdxW'(NumReq)) idx = idx - IdxW'(NumReq);
      if (!found && !rst_i && req_i[idx[ChW-1:0]]) begin
        found                = 1'b1;
        gnt_o[idx[ChW-1:0]]  = 1'b1;
        nxt                  = idx + 1'b1;
        if (nxt == IdxW'(NumReq)) nxt = '0;
        rr_d                 = nxt[ChW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end

endmodule

// File: rtl/cheri_trvk_multi_stage.sv
// Multi-requester revocation check: arbitrate, look up capability base in the TSMap, return clear-tag verdict.
// Latency: fixed 2 cycles from handshake to response; one-word lookup cache skips redundant map reads.
// Backpressure: none on responses; requests only wait for the round-robin grant (1 accept per cycle).
// Ports: req_* per-channel capability requests, tsmap_* map read port (1-cycle read), map_wr_i cache
//        invalidate, rsp_* one-hot verdict with echoed id and clear-tag flag.
module cheri_trvk_multi_stage
  import cheri_pkg::*;
#(
  parameter int unsigned NumReq       = 2,
  parameter logic [31:0] HeapBase     = 32'h2001_0000,
  parameter int unsigned TSMapWords   = 1024,
  parameter int unsigned GranuleShift = 3,
  parameter int unsigned IdWidth      = 5,
  localparam int unsigned AddrW       = $clog2(TSMapWords)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumReq-1:0]  req_valid_i,
  output logic [NumReq-1:0]  req_ready_o,
  input  reg_cap_t           req_cap_i  [NumReq],
  input  logic [31:0]        req_data_i [NumReq],
  input  logic [IdWidth-1:0] req_id_i   [NumReq],
  output logic               tsmap_cs_o,
  output logic [AddrW-1:0]   tsmap_addr_o,
  input  logic [31:0]        tsmap_rdata_i,
  input  logic               map_wr_i,
  output logic [NumReq-1:0]  rsp_valid_o,
  output logic [IdWidth-1:0] rsp_id_o,
  output logic               rsp_clrtag_o
);

  logic [NumReq-1:0] gnt;
  trvk_req_t         sel;

  cheri_rr_arb #(.NumReq(NumReq)) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (req_valid_i),
    .gnt_o (gnt)
  );

  assign req_ready_o = gnt;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (gnt[i]) begin
        sel.cap  = req_cap_i[i];
        sel.data = req_data_i[i];
        sel.id   = MaxIdW'(req_id_i[i]);
        sel.ch   = MaxChW'(i);
      end
    end
  end

  // Accept register: holds the request during its lookup cycle.
  logic      s1_vld;
  trvk_req_t s1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld <= 1'b0;
      s1     <= '0;
    end else begin
      s1_vld <= |gnt;
      if (|gnt) s1 <= sel;
    end
  end

  // Lookup: decode base into map word/bit and decide cache hit vs map read.
  logic [32:0]      bnd33;
  logic [31:0]      base32;
  logic [31:0]      off;
  logic [31:0]      wrd32;
  logic [4:0]       bidx;
  logic             chk;
  logic             hit;
  logic             cache_vld_q;
  logic [AddrW-1:0] cache_addr_q;
  logic [31:0]      cache_word_q;

  always_comb begin
    bnd33  = get_bound33(s1.cap.base, {2{s1.cap.base_cor}}, s1.cap.exp, s1.data);
    base32 = bnd33[31:0];
    off    = base32 - HeapBase;
    wrd32  = off >> (GranuleShift + 5);
    bidx   = off[GranuleShift +: 5];
    chk    = s1_vld && s1.cap.valid && (base32 >= HeapBase) &&
             (wrd32 < 32'(TSMapWords)) && !cap_is_sealed(s1.cap.cperms);
    // A same-cycle map write makes the cached word untrustworthy.
    hit    = cache_vld_q && (cache_addr_q == wrd32[AddrW-1:0]) && !map_wr_i;
  end

  assign tsmap_cs_o   = chk && !hit;
  assign tsmap_addr_o = tsmap_cs_o ? wrd32[AddrW-1:0] : '0;

  // Respond stage. The cached word is snapshotted on a hit so that a later
  // invalidate cannot disturb a request already in flight.
  logic              s2_vld;
  logic [MaxChW-1:0] s2_ch;
  logic [MaxIdW-1:0] s2_id;
  logic              s2_chk;
  logic [4:0]        s2_bit;
  logic              s2_use_cache;
  logic [31:0]       s2_snap;
  logic [AddrW-1:0]  s2_addr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_vld       <= 1'b0;
      s2_ch        <= '0;
      s2_id        <= '0;
      s2_chk       <= 1'b0;
      s2_bit       <= '0;
      s2_use_cache <= 1'b0;
      s2_snap      <= '0;
      s2_addr      <= '0;
    end else begin
      s2_vld       <= s1_vld;
      s2_ch        <= s1.ch;
      s2_id        <= s1.id;
      s2_chk       <= chk;
      s2_bit       <= bidx;
      s2_use_cache <= chk && hit;
      s2_snap      <= cache_word_q;
      s2_addr      <= wrd32[AddrW-1:0];
    end
  end

  logic [31:0] word;

  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (s2_vld && (s2_ch == MaxChW'(i))) rsp_valid_o[i] = 1'b1;
    end
    word         = s2_use_cache ? s2_snap : tsmap_rdata_i;
    rsp_id_o     = s2_vld ? s2_id[IdWidth-1:0] : '0;
    rsp_clrtag_o = s2_vld && s2_chk && word[s2_bit];
  end

  // Fill from a map read consumed in S2; any map write wins over the fill.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cache_vld_q  <= 1'b0;
      cache_addr_q <= '0;
      cache_word_q <= '0;
    end else if (map_wr_i) begin
      cache_vld_q  <= 1'b0;
    end else if (s2_vld && s2_chk && !s2_use_cache) begin
      cache_vld_q  <= 1'b1;
      cache_addr_q <= s2_addr;
      cache_word_q <= tsmap_rdata_i;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s1.cap.top, s1.cap.top_cor, bnd33[32], off, s2_id};

endmodule

// File: tb/tb_cheri_trvk_multi_stage.sv
module tb_cheri_trvk_multi_stage;
  import cheri_pkg::*;

  localparam int N = 2;
  localparam logic [31:0] HB = 32'h2001_0000;
  localparam int WORDS = 1024;
  localparam int GS = 3;
  localparam int IDW = 5;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req_valid, req_ready, rsp_valid;
  reg_cap_t       req_cap  [N];
  logic [31:0]    req_data [N];
  logic [IDW-1:0] req_id   [N];
  logic           tsmap_cs;
  logic [AW-1:0]  tsmap_addr;
  logic [31:0]    tsmap_rdata;
  logic           map_wr;
  logic [IDW-1:0] rsp_id;
  logic           rsp_clrtag;

  cheri_trvk_multi_stage #(
    .NumReq(N), .HeapBase(HB), .TSMapWords(WORDS), .GranuleShift(GS), .IdWidth(IDW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_cap_i(req_cap), .req_data_i(req_data), .req_id_i(req_id),
    .tsmap_cs_o(tsmap_cs), .tsmap_addr_o(tsmap_addr), .tsmap_rdata_i(tsmap_rdata),
    .map_wr_i(map_wr), .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_clrtag_o(rsp_clrtag)
  );

  // Staged stimulus for the next cycle.
  logic           rst_d;
  logic [N-1:0]   vld_d;
  reg_cap_t       cap_d [N];
  logic [31:0]    dat_d [N];
  logic [IDW-1:0] id_d  [N];
  logic           mwr_d;
  int             mwr_a;
  logic [31:0]    mwr_v;

  logic [31:0] mem [WORDS];
  logic [31:0] rd_next;
  int cmp_cnt, err_cnt, cyc, rr;

  typedef struct { int cyc; int ch; int id; reg_cap_t cap; logic [31:0] data; } acc_t;
  typedef struct { int cyc; int ch; int id; bit clr; } rsp_t;
  acc_t acc_q[$];
  rsp_t rsp_q[$];

  task automatic compare(string nm, logic [31:0] act, logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Base address rebuilt arithmetically: block-aligned address, optionally one
  // block lower, plus the 9-bit base field scaled by the exponent.
  function automatic logic [31:0] model_base(reg_cap_t c, logic [31:0] a);
    longint unsigned blk, hi;
    blk = 64'd1 << (int'(c.exp) + 9);
    hi  = 64'(a) / blk;
    if (c.base_cor) hi = hi - 1;
    return 32'(hi * blk + (64'(c.base) << c.exp));
  endfunction

  function automatic bit model_chk(reg_cap_t c, logic [31:0] b);
    bit sealed;
    sealed = (c.cperms[4:3] == 2'b00) && (c.cperms[2:0] != 3'b000);
    return c.valid && (b >= HB) && (((b - HB) >> (GS + 5)) < WORDS) && !sealed;
  endfunction

  task automatic step();
    rsp_t r;
    acc_t a;
    logic [N-1:0] eg, ev;
    int c, rr0, bi;
    bit found, ck;
    logic [31:0] b, w;
    @(posedge clk);
    #1;
    rst = rst_d;
    req_valid = vld_d;
    for (int i = 0; i < N; i++) begin
      req_cap[i] = cap_d[i]; req_data[i] = dat_d[i]; req_id[i] = id_d[i];
    end
    map_wr = mwr_d;
    tsmap_rdata = rd_next;
    @(negedge clk);
    cyc++;
    if (mwr_d) mem[mwr_a] = mwr_v;  // write-first map: reads this cycle see the new word
    if (rst_d) begin
      compare("rst_ready", 32'(req_ready), 0);
      compare("rst_cs", 32'(tsmap_cs), 0);
      compare("rst_addr", 32'(tsmap_addr), 0);
      compare("rst_rspv", 32'(rsp_valid), 0);
      compare("rst_clr", 32'(rsp_clrtag), 0);
      acc_q.delete(); rsp_q.delete(); rr = 0;
      rd_next = $urandom();
      return;
    end
    eg = '0; found = 0; rr0 = rr;
    for (int k = 0; k < N; k++) begin
      c = (rr0 + k) % N;
      if (!found && vld_d[c]) begin found = 1; eg[c] = 1'b1; rr = (c + 1) % N; end
    end
    compare("grant", 32'(req_ready), 32'(eg));
    ev = '0;
    r = '{cyc: 0, ch: 0, id: 0, clr: 0};
    if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
      r = rsp_q.pop_front();
      ev[r.ch] = 1'b1;
    end
    compare("rsp_valid", 32'(rsp_valid), 32'(ev));
    compare("rsp_id", 32'(rsp_id), 32'(r.id));
    compare("rsp_clrtag", 32'(rsp_clrtag), 32'(r.clr));
    if (acc_q.size() > 0 && acc_q[0].cyc == cyc - 1) begin
      a  = acc_q.pop_front();
      b  = model_base(a.cap, a.data);
      ck = model_chk(a.cap, b);
      w  = (b - HB) >> (GS + 5);
      bi = int'(((b - HB) >> GS) & 32'd31);
      if (!ck) compare("cs_nochk", 32'(tsmap_cs), 0);
      else if (tsmap_cs) compare("cs_addr", 32'(tsmap_addr), w);
      rsp_q.push_back('{cyc: cyc + 1, ch: a.ch, id: a.id, clr: ck && mem[w[9:0]][bi]});
    end else begin
      compare("cs_idle", 32'(tsmap_cs), 0);
    end
    rd_next = tsmap_cs ? mem[tsmap_addr] : $urandom();
    for (int i = 0; i < N; i++)
      if (eg[i]) acc_q.push_back('{cyc: cyc, ch: i, id: int'(id_d[i]), cap: cap_d[i], data: dat_d[i]});
  endtask

  task automatic set_req(input int ch, input logic [31:0] b, input logic [4:0] p,
                         input logic v, input int id);
    cap_d[ch] = '{valid: v, top: 9'h0, base: b[8:0], exp: 5'd0, cperms: p, top_cor: 1'b0, base_cor: 1'b0};
    dat_d[ch] = b;
    id_d[ch]  = IDW'(id);
    vld_d[ch] = 1'b1;
  endtask

  task automatic clear_reqs();
    vld_d = '0;
  endtask

  // One request on a quiet pipe: returns cs/addr seen at t+1 and the response at t+2.
  task automatic req1(input int ch, input logic [31:0] b, input logic [4:0] p, input logic v,
                      input int id, output logic cs1, output logic [AW-1:0] a1,
                      output logic [N-1:0] rv, output logic clr, output logic [IDW-1:0] rid);
    set_req(ch, b, p, v, id);
    step();
    clear_reqs();
    step();
    cs1 = tsmap_cs; a1 = tsmap_addr;
    step();
    rv = rsp_valid; clr = rsp_clrtag; rid = rsp_id;
  endtask

  task automatic map_write(input int a, input logic [31:0] v);
    mwr_d = 1'b1; mwr_a = a; mwr_v = v;
    step();
    mwr_d = 1'b0;
  endtask

  task automatic cache_run(input bit wr3, output logic [4:0] cs_v, output logic [4:0] clr_v);
    for (int k = 0; k < 5; k++) begin
      clear_reqs();
      if (k < 3) set_req(0, HB + 32'(8 * k), 5'b11111, 1'b1, k + 1);
      if (wr3 && k == 3) begin mwr_d = 1'b1; mwr_a = 0; mwr_v = 32'h2; end
      step();
      mwr_d = 1'b0;
      cs_v[k] = tsmap_cs;
      clr_v[k] = rsp_clrtag;
    end
    clear_reqs();
  endtask

  logic cs1, clr;
  logic [AW-1:0] a1;
  logic [N-1:0] rv;
  logic [IDW-1:0] rid;
  logic [4:0] cs_v, clr_v;

  initial begin
    cmp_cnt = 0; err_cnt = 0; cyc = 0; rr = 0;
    rst = 1'b1; req_valid = '0; map_wr = 1'b0; tsmap_rdata = '0;
    for (int i = 0; i < N; i++) begin
      req_cap[i] = '0; req_data[i] = '0; req_id[i] = '0;
      cap_d[i] = '0; dat_d[i] = '0; id_d[i] = '0;
    end
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom();
    mem[0] = 32'h0000_0200;
    rd_next = '0; mwr_d = 1'b0; mwr_a = 0; mwr_v = '0;

    // Reset with requests pending: nothing may be granted.
    rst_d = 1'b1;
    set_req(0, HB, 5'b11111, 1'b1, 1);
    set_req(1, HB, 5'b11111, 1'b1, 2);
    step(); step();
    rst_d = 1'b0; clear_reqs();
    step();

    // Basic revoke: base 0x2001_0048 -> word 0, bit 9.
    set_req(0, 32'h2001_0048, 5'b11111, 1'b1, 7);
    step();
    compare("t1_ready", 32'(req_ready), 32'h1);
    clear_reqs();
    step();
    compare("t1_cs", 32'(tsmap_cs), 1);
    compare("t1_addr", 32'(tsmap_addr), 0);
    step();
    compare("t1_rspv", 32'(rsp_valid), 32'h1);
    compare("t1_id", 32'(rsp_id), 7);
    compare("t1_clr", 32'(rsp_clrtag), 1);
    map_write(0, 32'h0);
    req1(0, 32'h2001_0048, 5'b11111, 1'b1, 7, cs1, a1, rv, clr, rid);
    compare("t1b_cs", 32'(cs1), 1);
    compare("t1b_clr", 32'(clr), 0);

    // Out of range below heap, at the map end, and the last mapped granule.
    req1(0, 32'h2000_FFF8, 5'b11111, 1'b1, 3, cs1, a1, rv, clr, rid);
    compare("low_cs", 32'(cs1), 0);
    compare("low_rspv", 32'(rv), 32'h1);
    compare("low_clr", 32'(clr), 0);
    req1(0, HB + 32'(WORDS * 256), 5'b11111, 1'b1, 4, cs1, a1, rv, clr, rid);
    compare("high_cs", 32'(cs1), 0);
    compare("high_clr", 32'(clr), 0);
    req1(0, HB + 32'(WORDS * 256) - 32'd8, 5'b11111, 1'b1, 5, cs1, a1, rv, clr, rid);
    compare("last_cs", 32'(cs1), 1);
    compare("last_addr", 32'(a1), 32'd1023);

    // Sealed and untagged capabilities are never looked up.
    req1(0, HB + 32'h48, 5'b00001, 1'b1, 6, cs1, a1, rv, clr, rid);
    compare("sealed_cs", 32'(cs1), 0);
    compare("sealed_clr", 32'(clr), 0);
    req1(0, HB + 32'h48, 5'b11111, 1'b0, 8, cs1, a1, rv, clr, rid);
    compare("untag_cs", 32'(cs1), 0);
    compare("untag_clr", 32'(clr), 0);
    req1(0, HB + 32'h100, 5'b00000, 1'b1, 9, cs1, a1, rv, clr, rid);
    compare("noperm_cs", 32'(cs1), 1);
    compare("noperm_addr", 32'(a1), 1);

    // Arbitration: both channels valid for four cycles from a fresh pointer.
    rst_d = 1'b1; step(); rst_d = 1'b0;
    set_req(0, HB + 32'h10, 5'b11111, 1'b1, 10);
    set_req(1, HB + 32'h20, 5'b11111, 1'b1, 20);
    for (int k = 0; k < 4; k++) begin
      step();
      compare("arb_gnt", 32'(req_ready), (k % 2) ? 32'h2 : 32'h1);
      if (k >= 2) begin
        compare("arb_rsp_ch", 32'(rsp_valid), (k % 2) ? 32'h2 : 32'h1);
        compare("arb_rsp_id", 32'(rsp_id), (k % 2) ? 32'd20 : 32'd10);
      end
    end
    clear_reqs(); step(); step();

    // Cache: three back-to-back requests to word 0 (bits 0,1,2 of 0x5).
    map_write(0, 32'h5);
    cache_run(1'b0, cs_v, clr_v);
    compare("cache_cs", 32'(cs_v), 32'b00110);
    compare("cache_clr", 32'(clr_v), 32'b10100);
    map_write(0, 32'h5);
    cache_run(1'b1, cs_v, clr_v);
    compare("inval_cs", 32'(cs_v), 32'b01110);
    compare("inval_clr", 32'(clr_v), 32'b00100);

    // Reset with S1 and S2 occupied: responses dropped, pointer and cache cleared.
    set_req(0, HB, 5'b11111, 1'b1, 11);
    step(); step();
    clear_reqs(); rst_d = 1'b1;
    step();
    rst_d = 1'b0;
    step();
    compare("rstmid_rsp0", 32'(rsp_valid), 0);
    step();
    compare("rstmid_rsp1", 32'(rsp_valid), 0);
    set_req(0, HB, 5'b11111, 1'b1, 12);
    set_req(1, HB, 5'b11111, 1'b1, 13);
    step();
    compare("rstmid_gnt", 32'(req_ready), 32'h1);
    clear_reqs();
    step();
    compare("rstmid_miss", 32'(tsmap_cs), 1);
    step(); step();

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      rst_d = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < N; i++) begin
        vld_d[i] = ($urandom_range(0, 2) != 0);
        cap_d[i].valid    = ($urandom_range(0, 7) != 0);
        cap_d[i].top      = 9'($urandom());
        cap_d[i].base     = 9'($urandom());
        cap_d[i].exp      = 5'($urandom_range(0, 3));
        cap_d[i].cperms   = 5'($urandom());
        cap_d[i].top_cor  = 1'($urandom());
        cap_d[i].base_cor = 1'($urandom());
        case ($urandom_range(0, 3))
          0:       dat_d[i] = HB - 32'h400 + 32'($urandom_range(0, 32'h800));
          3:       dat_d[i] = HB + 32'h3_FC00 + 32'($urandom_range(0, 32'h800));
          default: dat_d[i] = HB + 32'($urandom_range(0, 32'h1000));
        endcase
        id_d[i] = IDW'($urandom());
      end
      mwr_d = ($urandom_range(0, 11) == 0);
      mwr_a = $urandom_range(0, 3);
      mwr_v = $urandom();
      step();
    end
    rst_d = 1'b0; clear_reqs(); mwr_d = 1'b0;
    step(); step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
